// File: rtl/alu_seq_xlen.sv
// alu_seq_xlen: handshaked EX-stage ALU with registered result and an
// optional iterative radix-2 multiply/divide unit (macro ALU_SEQ_MULDIV_EN).
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, op, src1, src2
// (request side); out_valid/out_ready, result, zero_flag (response side);
// busy is high while an operation is in flight or waiting to be taken.
module alu_seq_xlen #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero_flag,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] base_res;
    logic [XLEN-1:0] fast_res;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign sh       = src2[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (op[3:0])
            4'b0000: base_res = src1 + src2;
            4'b0001: base_res = src1 - src2;
            4'b0010: base_res = src1 << sh;
            4'b0011: base_res = {{(XLEN-1){1'b0}},
                                 ($signed(src1) < $signed(src2))};
            4'b0100: base_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
            4'b0101: base_res = src1 ^ src2;
            4'b0110: base_res = src1 >> sh;
            4'b0111: base_res = $unsigned($signed(src1) >>> sh);
            4'b1000: base_res = src1 | src2;
            4'b1001: base_res = src1 & src2;
            default: base_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // acc holds {hi, lo} of the product, or {remainder, quotient}
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nx;
    logic [2*XLEN-1:0] fix;
    logic [XLEN-1:0]   mcand;
    logic [CW-1:0]     cnt;
    logic [2:0]        mop;
    logic              neg_res;
    logic              neg_rem;

    logic              sgn1;
    logic              sgn2;
    logic              s1neg;
    logic              s2neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;

    logic [XLEN:0]     msum;
    logic [XLEN:0]     dtrial;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rmd;
    logic [XLEN-1:0]   m_res;

    always_comb begin
        // signed dividend/divisor for div/rem; mulh both, mulhsu src1 only
        sgn1     = op[2] ? !op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        sgn2     = op[2] ? !op[0] : (op[1:0] == 2'b01);
        s1neg    = sgn1 & src1[XLEN-1];
        s2neg    = sgn2 & src2[XLEN-1];
        a_mag    = s1neg ? -src1 : src1;
        b_mag    = s2neg ? -src2 : src2;
        div_zero = op[2] && (src2 == '0);
        div_ovf  = op[2] && !op[0] && (src1 == MIN_NEG) && (src2 == '1);
        fast     = !op[4] || op[3] || div_zero || div_ovf;
        fast_res = '0;
        if (!op[4]) begin
            fast_res = base_res;
        end else if (op[3]) begin
            fast_res = '0;
        end else if (div_zero) begin
            fast_res = op[1] ? src1 : '1;
        end else if (div_ovf) begin
            fast_res = op[1] ? '0 : src1;
        end
    end

    always_comb begin
        msum   = {1'b0, acc[2*XLEN-1:XLEN]}
               + {1'b0, (acc[0] ? mcand : '0)};
        dtrial = acc[2*XLEN-1:XLEN-1] - {1'b0, mcand};
        if (mop[2]) begin
            // restoring division step: keep the trial remainder on no borrow
            if (!dtrial[XLEN])
                acc_nx = {dtrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_nx = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            acc_nx = {msum, acc[XLEN-1:1]};
        end
        fix = neg_res ? -acc_nx : acc_nx;
        quo = neg_res ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        rmd = neg_rem ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        if (mop == 3'b000)
            m_res = fix[XLEN-1:0];
        else if (!mop[2])
            m_res = fix[2*XLEN-1:XLEN];
        else if (!mop[1])
            m_res = quo;
        else
            m_res = rmd;
    end
`else
    assign fast_res = op[4] ? '0 : base_res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero_flag <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            acc       <= '0;
            mcand     <= '0;
            cnt       <= '0;
            mop       <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
                        if (fast) begin
                            result    <= fast_res;
                            zero_flag <= (fast_res == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            acc     <= {{XLEN{1'b0}}, a_mag};
                            mcand   <= b_mag;
                            mop     <= op[2:0];
                            neg_res <= s1neg ^ s2neg;
                            neg_rem <= s1neg;
                            cnt     <= CW'(XLEN);
                            state   <= CALC;
                        end
`else
                        result    <= fast_res;
                        zero_flag <= (fast_res == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
`endif
                    end
                end
                CALC: begin
`ifdef ALU_SEQ_MULDIV_EN
                    acc <= acc_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result    <= m_res;
                        zero_flag <= (m_res == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_xlen.sv
// tb_alu_seq_xlen: directed plus random checks of alu_seq_xlen (XLEN=32)
// against an arithmetic reference model; M-op expectations follow the macro.
module tb_alu_seq_xlen;

    localparam int XLEN = 32;
`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      op = '0;
    logic [XLEN-1:0] src1 = '0;
    logic [XLEN-1:0] src2 = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            zero_flag;
    logic            busy;

    int n_checks = 0;
    int n_err = 0;

    alu_seq_xlen #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero_flag (zero_flag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [4:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          p;
        int              amt = int'(b[4:0]);
        p = 0;
        case (o)
            5'b00000: p = longint'(a + b);
            5'b00001: p = longint'(a - b);
            5'b00010: p = longint'(a << amt);
            5'b00011: p = (sa < sb) ? 1 : 0;
            5'b00100: p = (ua < ub) ? 1 : 0;
            5'b00101: p = longint'(a ^ b);
            5'b00110: p = longint'(a >> amt);
            5'b00111: p = sa >>> amt;
            5'b01000: p = longint'(a | b);
            5'b01001: p = longint'(a & b);
            default:  p = 0;
        endcase
        if (MD && o[4:3] == 2'b10) begin
            case (o[2:0])
                3'b000: p = longint'(ua * ub);
                3'b001: p = (sa * sb) >>> 32;
                3'b010: p = (sa * longint'(ub)) >>> 32;
                3'b011: p = longint'((ua * ub) >> 32);
                3'b100: p = (b == 0) ? -1 :
                            (a == 32'h8000_0000 && b == '1) ? sa : sa / sb;
                3'b101: p = (b == 0) ? -1 : longint'(ua / ub);
                3'b110: p = (b == 0) ? sa :
                            (a == 32'h8000_0000 && b == '1) ? 0 : sa % sb;
                default: p = (b == 0) ? sa : longint'(ua % ub);
            endcase
        end
        return p[31:0];
    endfunction

    function automatic int ref_lat(input logic [4:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        bit special;
        special = o[2] && (b == 0 ||
                  (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        if (MD && o[4:3] == 2'b10 && !special) return XLEN + 1;
        return 1;
    endfunction

    task automatic do_op(input string tag, input logic [4:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        logic [31:0] exp;
        int lat;
        exp = ref_res(o, a, b);
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(1));
        in_valid  = 1'b1;
        op        = o;
        src1      = a;
        src2      = b;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = $urandom;
        src2     = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(ref_lat(o, a, b)));
        chk({tag, ".result"}, 64'(result), 64'(exp));
        chk({tag, ".zero"}, 64'(zero_flag), 64'(exp == 0));
        chk({tag, ".busy"}, 64'(busy), 64'(1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op       = 5'b00000;
            src1     = $urandom;
            src2     = $urandom;
            @(posedge clk);
            #1;
            chk({tag, ".hold_result"}, 64'(result), 64'(exp));
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".drained_valid"}, 64'(out_valid), 64'(0));
        chk({tag, ".drained_in_ready"}, 64'(in_ready), 64'(1));
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'(1));
        chk("rst.out_valid", 64'(out_valid), 64'(0));
        chk("rst.result", 64'(result), 64'(0));
        chk("rst.zero", 64'(zero_flag), 64'(0));
        chk("rst.busy", 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_op("add", 5'b00000, 32'd5, 32'd7, 0);
        do_op("sub_zero", 5'b00001, 32'd7, 32'd7, 0);
        do_op("sra", 5'b00111, 32'h8000_0000, 32'd4, 0);
        do_op("srl", 5'b00110, 32'h8000_0000, 32'd4, 0);
        do_op("sra_hi", 5'b00111, 32'h8000_0000, 32'h24, 0);
        do_op("srl_hi", 5'b00110, 32'h8000_0000, 32'h24, 0);
        do_op("slt", 5'b00011, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("sltu", 5'b00100, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("nop", 5'b01111, 32'd9, 32'd9, 0);
        do_op("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("mul", 5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("mulh", 5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("div", 5'b10100, -32'sd7, 32'd2, 0);
        do_op("rem", 5'b10110, -32'sd7, 32'd2, 0);
        do_op("divu_z", 5'b10101, 32'd100, 32'd0, 0);
        do_op("remu_z", 5'b10111, 32'd100, 32'd0, 0);
        do_op("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("mul_3x4", 5'b10000, 32'd3, 32'd4, 0);
        do_op("m_11xxx", 5'b11010, 32'd3, 32'd4, 0);
        do_op("hold", 5'b01001, 32'hF0F0_1234, 32'h0FF0_FF00, 5);

        // reset in the middle of a divide
        @(negedge clk);
        in_valid  = 1'b1;
        op        = 5'b10101;
        src1      = 32'd1000;
        src2      = 32'd3;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", 64'(out_valid), 64'(0));
        chk("abort.in_ready", 64'(in_ready), 64'(1));
        chk("abort.busy", 64'(busy), 64'(0));
        chk("abort.result", 64'(result), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst_add", 5'b00000, 32'h1234_5678, 32'h1111_1111, 0);

        for (int i = 0; i < 60; i++) begin
            logic [4:0] ro;
            ro = 5'($urandom_range(0, 31));
            do_op($sformatf("rnd%0d_op%0h", i, ro), ro, pick(), pick(),
                  int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
